ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Execute-stage multiply/divide unit beside the ALU. Takes the same rs/rt operands
//  (data1/data2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO registers.
//  Holds the pipeline (busy) while a multi-cycle op runs; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  DIV_ITERS  32  radix-2 restoring-divide iterations; equals the operand width, fixed at 32
// PORTS
//  clk       in   1   clock, rising edge
//  resetn    in   1   synchronous active-low reset
//  op_valid  in   1   op request from the ID/EX register
//  op        in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved
//  data1     in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//  data2     in   32  rt operand (divisor / multiplier)
//  flush     in   1   exception/eret flush; aborts the current op
//  busy      out  1   op in progress; EX stage stalls while high
//  done      out  1   one-cycle pulse: HI/LO now hold the result
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): hi=lo=0, state IDLE, busy=0, done=0, counter=0. Reset mid-op
//    abandons the op; reset overrides flush and op_valid.
//  - States: IDLE, MUL, DIV, DONE. busy=1 in MUL and DIV only. done=1 in DONE only.
//  - Accept: op_valid=1 and state is IDLE or DONE. No accept in MUL or DIV; op_valid there is
//    ignored. ID/EX holds the request stable while busy.
//  - MTHI/MTLO: hi (or lo) <= data1 at the accept edge. No state change, no busy, no done.
//  - MULT/MULTU: accept edge E0 -> MUL. At E1 {hi,lo} <= 64-bit product (signed for MULT,
//    unsigned for MULTU) -> DONE. done=1 and busy=0 in the cycle after E1.
//  - DIV/DIVU: at E0 latch |data1| and |data2| (signed: two's-complement magnitude, so
//    0x80000000 -> 0x80000000) plus sign flags, clear counter -> DIV. One iteration per edge
//    E1..E32. At E32: lo <= quotient, hi <= remainder -> DONE (busy high 32 cycles).
//  - Signed fix-up: negate the quotient if the operand signs differ; the remainder takes the
//    dividend's sign. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. No overflow flag.
//  - Divide by zero (data2=0 at E0): full 32-cycle timing and done pulse; hi/lo unchanged.
//  - DONE lasts one cycle. It returns to IDLE, or starts the next op if one is accepted that
//    cycle (back-to-back).
//  - flush=1 at an edge: state <= IDLE, done <= 0, pending result discarded, hi/lo untouched.
//    flush beats op_valid in the same cycle, so nothing is accepted.
//  - flush in DONE: hi/lo keep the already-written result, and done drops.
//  - Reserved op codes: accepted and treated as no-ops with no state change.
//  - Product and quotient are computed from operands latched at E0; later data1/data2 changes
//    have no effect.
// TESTING
//  1. MULT 0xFFFFFFFF x 0x00000002 -> busy 1 cycle, then done; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
//  2. DIV -7 (0xFFFFFFF9) / 2 -> busy exactly 32 cycles, then done; lo=0xFFFFFFFD,
//     hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
//  3. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 with prior hi=0x11,
//     lo=0x22 -> done after 32 busy cycles; hi=0x11, lo=0x22.
//  4. DIVU 100/7, flush on busy cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//     A new MULTU 3x4 then gives lo=12, hi=0.
//  5. MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> hi/lo updated one edge
//     after each, busy never high. MULT in DONE cycle of a DIV -> accepted with no idle gap.
//  6. resetn=0 on DIV cycle 20 -> next cycle hi=lo=0, busy=0, done=0. Random signed/unsigned
//     mul/div (incl. 0, 1, -1, 0x80000000) checked against a reference model.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Ports: clk, resetn, op_valid, op, data1, data2, flush -> busy, done, hi, lo.
module ex_muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] a_q, b_q, rem_q;
  logic [5:0]  cnt;
  logic        sgn_q, neg_q, rneg_q, dz_q;

  logic is_mul, is_div, is_mthi, is_mtlo;
  logic can_acc, accept, last;
  logic sgn_op;
  logic [31:0] abs1, abs2;

  logic signed [63:0] prod;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nx, quo_nx, q_fix, r_fix;

  assign is_mul  = op[2:1] == 2'b00;
  assign is_div  = op[2:1] == 2'b01;
  assign is_mthi = op == 3'b100;
  assign is_mtlo = op == 3'b101;
  assign sgn_op  = ~op[0];

  assign can_acc = (state == S_IDLE) || (state == S_DONE);
  assign accept  = op_valid && !flush && can_acc;
  assign last    = cnt == 6'(DIV_ITERS - 1);

  // Two's-complement magnitude; 0x80000000 maps to itself.
  assign abs1 = (sgn_op && data1[31]) ? -data1 : data1;
  assign abs2 = (sgn_op && data2[31]) ? -data2 : data2;

  assign prod = $signed({sgn_q & a_q[31], a_q})
              * $signed({sgn_q & b_q[31], b_q});

  // Restoring step: a_q doubles as the dividend/quotient shifter.
  assign rem_sh = {rem_q, a_q[31]};
  assign ge     = rem_sh >= {1'b0, b_q};
  assign rem_nx = ge ? 32'(rem_sh - {1'b0, b_q})
                     : rem_sh[31:0];
  assign quo_nx = {a_q[30:0], ge};
  assign q_fix  = neg_q  ? -quo_nx : quo_nx;
  assign r_fix  = rneg_q ? -rem_nx : rem_nx;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = state == S_DONE;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          state_nxt = S_IDLE;
          if (op_valid && is_mul) state_nxt = S_MUL;
          if (op_valid && is_div) state_nxt = S_DIV;
        end
        S_MUL: state_nxt = S_DONE;
        S_DIV: if (last) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi     <= '0;
      lo     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      cnt    <= '0;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (is_mthi) hi <= data1;
        if (is_mtlo) lo <= data1;
        if (is_mul || is_div) begin
          a_q    <= is_div ? abs1 : data1;
          b_q    <= is_div ? abs2 : data2;
          sgn_q  <= sgn_op;
          neg_q  <= sgn_op && (data1[31] ^ data2[31]);
          rneg_q <= sgn_op && data1[31];
          dz_q   <= data2 == '0;
          rem_q  <= '0;
          cnt    <= '0;
        end
      end
      if (!flush && state == S_MUL) begin
        {hi, lo} <= prod;
      end
      if (!flush && state == S_DIV) begin
        rem_q <= rem_nx;
        a_q   <= quo_nx;
        cnt   <= cnt + 6'd1;
        if (last && !dz_q) begin
          lo <= q_fix;
          hi <= r_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomised checks for ex_muldiv_unit.
// Drives at the falling edge, samples just before driving.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] data1, data2;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .data1(data1), .data2(data2), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001;
  localparam logic [2:0] DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;
  localparam logic [2:0] RSVD = 3'b110;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          cyc;
    logic        done;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the first falling edge with busy low.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    op_valid = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'($urandom);
    data1 = $urandom;
    data2 = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] mh, ml, ra, rb;
    logic [2:0] ro;
    logic [63:0] p;
    longint sa, sb;
    logic [31:0] pick[4];

    tv[0]  = '{MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 1};
    tv[1]  = '{MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1, 1};
    tv[2]  = '{DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1};
    tv[3]  = '{DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 32, 1};
    tv[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32, 1};
    tv[5]  = '{MTHI,  32'h11, 32'h0, 32'h11, 32'h80000000, 0, 0};
    tv[6]  = '{MTLO,  32'h22, 32'h0, 32'h11, 32'h22, 0, 0};
    tv[7]  = '{DIVU,  32'd5, 32'd0, 32'h11, 32'h22, 32, 1};
    tv[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1, 1};
    tv[9]  = '{DIV,   32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 32, 1};
    tv[10] = '{DIVU,  32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 32, 1};
    tv[11] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1, 1};
    tv[12] = '{RSVD,  32'h1234, 32'h5678, 32'hFFFFFFFE, 32'h1, 0, 0};
    tv[13] = '{DIV,   32'h0, 32'd5, 32'h0, 32'h0, 32, 1};

    resetn = 1'b0; op_valid = 1'b0; op = '0;
    data1 = '0; data2 = '0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].a, tv[i].b, cyc);
      chk($sformatf("v%0d_cyc", i), 64'(cyc), 64'(tv[i].cyc));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(tv[i].done));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(tv[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(tv[i].lo));
      @(negedge clk);
    end

    // Flush on busy cycle 10 of a divide.
    issue(MTHI, 32'hAA, 32'h0, cyc);
    issue(MTLO, 32'hBB, 32'h0, cyc);
    op_valid = 1'b1; op = DIVU; data1 = 32'd100; data2 = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 2; i <= 10; i++) @(negedge clk);
    chk("fl_busy_before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", 64'(busy), 64'h0);
    chk("fl_done", 64'(done), 64'h0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) chk("fl_late_done", 64'(done), 64'h0);
    end
    chk("fl_hi", 64'(hi), 64'hAA);
    chk("fl_lo", 64'(lo), 64'hBB);
    issue(MULTU, 32'd3, 32'd4, cyc);
    chk("fl_mul_hi", 64'(hi), 64'h0);
    chk("fl_mul_lo", 64'(lo), 64'd12);

    // MTHI then MTLO back-to-back.
    op_valid = 1'b1; op = MTHI; data1 = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi_busy", 64'(busy), 64'h0);
    op = MTLO; data1 = 32'h12345678;
    @(negedge clk);
    op_valid = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    chk("mtlo_hi", 64'(hi), 64'hDEADBEEF);
    chk("mtlo_busy", 64'(busy), 64'h0);

    // MULT accepted in the DONE cycle of a DIVU.
    issue(DIVU, 32'd100, 32'd7, cyc);
    chk("b2b_div_done", 64'(done), 64'h1);
    op_valid = 1'b1; op = MULT; data1 = 32'hFFFFFFFF; data2 = 32'h2;
    @(negedge clk);
    op_valid = 1'b0;
    chk("b2b_busy", 64'(busy), 64'h1);
    chk("b2b_div_res", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    chk("b2b_mul_done", 64'(done), 64'h1);
    chk("b2b_mul_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

    // Flush in DONE beats a simultaneous request.
    issue(DIVU, 32'd100, 32'd7, cyc);
    chk("fdone_done", 64'(done), 64'h1);
    flush = 1'b1; op_valid = 1'b1; op = MULTU;
    data1 = 32'd9; data2 = 32'd9;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    chk("fdone_done_drop", 64'(done), 64'h0);
    chk("fdone_busy", 64'(busy), 64'h0);
    chk("fdone_res", {hi, lo}, {32'd2, 32'd14});

    // Reset on busy cycle 20 of a divide.
    op_valid = 1'b1; op = DIV; data1 = 32'hFFFFFFF9; data2 = 32'd2;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 2; i <= 20; i++) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_mid_res", {hi, lo}, 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_done", 64'(done), 64'h0);
    @(negedge clk);

    // Randomised ops against a 64-bit reference.
    mh = 32'h0; ml = 32'h0;
    pick[0] = 32'h0; pick[1] = 32'h1;
    pick[2] = 32'hFFFFFFFF; pick[3] = 32'h80000000;
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      if (i < 3) rb = 32'h0;
      if (ro == MULT) begin
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        p = 64'(sa * sb);
        {mh, ml} = p;
      end else if (ro == MULTU) begin
        p = {32'h0, ra} * {32'h0, rb};
        {mh, ml} = p;
      end else if (rb != 0) begin
        if (ro == DIV) begin
          sa = longint'($signed(ra));
          sb = longint'($signed(rb));
        end else begin
          sa = longint'({32'h0, ra});
          sb = longint'({32'h0, rb});
        end
        ml = 32'(sa / sb);
        mh = 32'(sa % sb);
      end
      issue(ro, ra, rb, cyc);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb),
          {hi, lo}, {mh, ml});
      chk($sformatf("rnd%0d_cyc", i), 64'(cyc),
          (ro[1] ? 64'd32 : 64'd1));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
